ram_uart_arbiter: RTL and testbench

Two-requester arbiter that shares the single block RAM port and the UART transmitter between the monitor (requester 0) and the CPU (requester 1). It replaces a static ownership mux with per-transaction request/acknowledge handshakes, so both masters can interleave RAM accesses and transmit bytes safely. It sits in `top` between the monitor FSM, `cpu`, `ram` and `uart`.

---
 rtl/ram_uart_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_ram_uart_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_uart_arbiter.sv
// ram_uart_arbiter: shares the block RAM port and the UART transmitter between
// the monitor (requester 0) and the CPU (requester 1) with per-transaction
// request/acknowledge handshakes. The RAM and TX paths are independent FSMs.
// Optional build macro ARB_MONITOR_PRIORITY_EN: requester 0 wins every tie
// (no round-robin); requester 1 may starve.
module ram_uart_arbiter #(
  parameter int unsigned addr_width = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [addr_width-1:0] addr0,
  input  logic [addr_width-1:0] addr1,
  input  logic [7:0]            wdata0,
  input  logic [7:0]            wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [7:0]            rdata0,
  output logic [7:0]            rdata1,
  input  logic                  txreq0,
  input  logic                  txreq1,
  input  logic [7:0]            txbyte0,
  input  logic [7:0]            txbyte1,
  output logic                  txack0,
  output logic                  txack1,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_waddr,
  output logic [addr_width-1:0] ram_raddr,
  output logic [7:0]            ram_din,
  input  logic [7:0]            ram_dout,
  output logic                  uart_transmit,
  output logic [7:0]            uart_tx_byte,
  input  logic                  uart_is_transmitting
);

  typedef enum logic [1:0] {R_IDLE, R_ACCESS, R_DONE} ram_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_WAIT} tx_state_t;

  ram_state_t            ram_state_q, ram_state_d;
  tx_state_t             tx_state_q, tx_state_d;
  logic                  ram_gnt_q, ram_gnt_d;
  logic                  ram_wr_q, ram_wr_d;
  logic                  ram_last_q, ram_last_d;
  logic                  tx_gnt_q, tx_gnt_d;
  logic                  tx_last_q, tx_last_d;
  logic                  tw_armed_q, tw_armed_d;
  logic                  ack0_d, ack1_d, txack0_d, txack1_d;
  logic [7:0]            rdata0_d, rdata1_d, ram_din_d, uart_tx_byte_d;
  logic                  ram_we_d, uart_transmit_d;
  logic [addr_width-1:0] ram_waddr_d, ram_raddr_d;
  logic                  ram_win, tx_win;
  logic                  ram_m0, ram_m1, tx_m0, tx_m1;

  // Winner of a two-way request; callers guarantee at least one request is set.
  function automatic logic arb_pick(input logic r0, input logic r1, input logic last);
`ifdef ARB_MONITOR_PRIORITY_EN
    arb_pick = ~r0;
`else
    arb_pick = (r0 && r1) ? ~last : r1;
`endif
  endfunction

  // A request is ignored during its own ack cycle so it is not re-served twice.
  assign ram_m0 = req0 & ~ack0;
  assign ram_m1 = req1 & ~ack1;
  assign tx_m0  = txreq0 & ~txack0;
  assign tx_m1  = txreq1 & ~txack1;

  // State and output registers for both paths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_state_q   <= R_IDLE;
      tx_state_q    <= T_IDLE;
      ram_gnt_q     <= 1'b0;
      ram_wr_q      <= 1'b0;
      ram_last_q    <= 1'b1;
      tx_gnt_q      <= 1'b0;
      tx_last_q     <= 1'b1;
      tw_armed_q    <= 1'b0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      txack0        <= 1'b0;
      txack1        <= 1'b0;
      rdata0        <= 8'h00;
      rdata1        <= 8'h00;
      ram_we        <= 1'b0;
      ram_waddr     <= '0;
      ram_raddr     <= '0;
      ram_din       <= 8'h00;
      uart_transmit <= 1'b0;
      uart_tx_byte  <= 8'h00;
    end else begin
      ram_state_q   <= ram_state_d;
      tx_state_q    <= tx_state_d;
      ram_gnt_q     <= ram_gnt_d;
      ram_wr_q      <= ram_wr_d;
      ram_last_q    <= ram_last_d;
      tx_gnt_q      <= tx_gnt_d;
      tx_last_q     <= tx_last_d;
      tw_armed_q    <= tw_armed_d;
      ack0          <= ack0_d;
      ack1          <= ack1_d;
      txack0        <= txack0_d;
      txack1        <= txack1_d;
      rdata0        <= rdata0_d;
      rdata1        <= rdata1_d;
      ram_we        <= ram_we_d;
      ram_waddr     <= ram_waddr_d;
      ram_raddr     <= ram_raddr_d;
      ram_din       <= ram_din_d;
      uart_transmit <= uart_transmit_d;
      uart_tx_byte  <= uart_tx_byte_d;
    end
  end

  // RAM path: grant and latch in IDLE, write strobe during ACCESS, ack in DONE.
  always_comb begin
    ram_state_d = ram_state_q;
    ram_gnt_d   = ram_gnt_q;
    ram_wr_d    = ram_wr_q;
    ram_last_d  = ram_last_q;
    ram_win     = 1'b0;
    ram_we_d    = 1'b0;
    ram_waddr_d = ram_waddr;
    ram_raddr_d = ram_raddr;
    ram_din_d   = ram_din;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0;
    rdata1_d    = rdata1;
    case (ram_state_q)
      R_IDLE: begin
        if (ram_m0 || ram_m1) begin
          ram_win     = arb_pick(ram_m0, ram_m1, ram_last_q);
          ram_gnt_d   = ram_win;
          ram_last_d  = ram_win;
          ram_wr_d    = ram_win ? we1 : we0;
          ram_we_d    = ram_win ? we1 : we0;
          ram_waddr_d = ram_win ? addr1 : addr0;
          ram_raddr_d = ram_win ? addr1 : addr0;
          ram_din_d   = ram_win ? wdata1 : wdata0;
          ram_state_d = R_ACCESS;
        end
      end
      R_ACCESS: ram_state_d = R_DONE;
      R_DONE: begin
        if (ram_gnt_q) begin
          ack1_d = 1'b1;
          if (!ram_wr_q) rdata1_d = ram_dout;
        end else begin
          ack0_d = 1'b1;
          if (!ram_wr_q) rdata0_d = ram_dout;
        end
        ram_state_d = R_IDLE;
      end
      default: ram_state_d = R_IDLE;
    endcase
  end

  // TX path: grant when UART idle, one-cycle strobe plus txack, then hold off
  // at least two cycles so the UART busy flag has time to rise.
  always_comb begin
    tx_state_d      = tx_state_q;
    tx_gnt_d        = tx_gnt_q;
    tx_last_d       = tx_last_q;
    tw_armed_d      = tw_armed_q;
    tx_win          = 1'b0;
    uart_transmit_d = 1'b0;
    uart_tx_byte_d  = uart_tx_byte;
    txack0_d        = 1'b0;
    txack1_d        = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if ((tx_m0 || tx_m1) && !uart_is_transmitting) begin
          tx_win         = arb_pick(tx_m0, tx_m1, tx_last_q);
          tx_gnt_d       = tx_win;
          tx_last_d      = tx_win;
          uart_tx_byte_d = tx_win ? txbyte1 : txbyte0;
          tx_state_d     = T_START;
        end
      end
      T_START: begin
        uart_transmit_d = 1'b1;
        txack0_d        = ~tx_gnt_q;
        txack1_d        = tx_gnt_q;
        tw_armed_d      = 1'b0;
        tx_state_d      = T_WAIT;
      end
      T_WAIT: begin
        if (!tw_armed_q) tw_armed_d = 1'b1;
        else if (!uart_is_transmitting) tx_state_d = T_IDLE;
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_uart_arbiter.sv
// Directed self-checking bench for ram_uart_arbiter with a synchronous RAM model
// and a UART model that stays busy for 20 cycles after each strobe.
module tb_ram_uart_arbiter;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [7:0]    wdata0 = 0, wdata1 = 0;
  logic          ack0, ack1;
  logic [7:0]    rdata0, rdata1;
  logic          txreq0 = 0, txreq1 = 0;
  logic [7:0]    txbyte0 = 0, txbyte1 = 0;
  logic          txack0, txack1;
  logic          ram_we;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout = 8'h00;
  logic          uart_transmit;
  logic [7:0]    uart_tx_byte;
  logic          uart_is_transmitting;

  int n_tests = 0;
  int n_fail  = 0;

  ram_uart_arbiter #(.addr_width(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .txreq0(txreq0), .txreq1(txreq1), .txbyte0(txbyte0), .txbyte1(txbyte1),
    .txack0(txack0), .txack1(txack1),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model, one-cycle read latency.
  logic [7:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_din;
    ram_dout <= mem[ram_raddr];
  end

  // UART model: busy for 20 cycles after a strobe; flags a strobe while busy.
  int   busy_cnt = 0;
  logic strobe_busy_err = 1'b0;
  always @(posedge clk) begin
    if (uart_transmit && busy_cnt != 0) strobe_busy_err <= 1'b1;
    if (uart_transmit) busy_cnt <= 20;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_is_transmitting = (busy_cnt != 0);

  // One RAM transaction; returns ack latency in cycles, ram_we high count and read data.
  task automatic ram_op(input logic port, input logic we, input logic [AW-1:0] addr,
                        input logic [7:0] wd, output int lat, output int we_cycles,
                        output logic [7:0] rd);
    @(posedge clk); #1;
    if (port) begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wd; end
    else      begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wd; end
    lat = -1; we_cycles = 0; rd = 8'h00;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ram_we) we_cycles++;
      if ((port ? ack1 : ack0) === 1'b1) begin
        lat = n;
        rd  = port ? rdata1 : rdata0;
        break;
      end
    end
    if (port) req1 = 0; else req0 = 0;
  endtask

  // Both requesters read at once; returns ack cycle and data for each.
  task automatic ram_tie(output int t0, output int t1, output logic [7:0] r0, output logic [7:0] r1);
    @(posedge clk); #1;
    req0 = 1; we0 = 0; addr0 = AW'(10'h010);
    req1 = 1; we1 = 0; addr1 = AW'(10'h020);
    t0 = -1; t1 = -1; r0 = 8'h00; r1 = 8'h00;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (ack0 === 1'b1 && t0 < 0) begin t0 = n; r0 = rdata0; req0 = 0; end
      if (ack1 === 1'b1 && t1 < 0) begin t1 = n; r1 = rdata1; req1 = 0; end
      if (t0 > 0 && t1 > 0) break;
    end
    req0 = 0; req1 = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({ack0, ack1, txack0, txack1, ram_we, uart_transmit} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 000000",
                         {ack0, ack1, txack0, txack1, ram_we, uart_transmit});
    end
    n_tests++;
    if ({rdata0, rdata1, ram_din, uart_tx_byte} !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 00000000",
                         {rdata0, rdata1, ram_din, uart_tx_byte});
    end
    n_tests++;
    if ({ram_waddr, ram_raddr} !== '0) begin
      n_fail++; $display("FAIL reset_addr: got %h/%h expected 0/0", ram_waddr, ram_raddr);
    end
    rst_n = 1;
  endtask

  task automatic test_write_read;
    int lat, wc; logic [7:0] rd;
    ram_op(1'b0, 1'b1, AW'(10'h005), 8'hA5, lat, wc, rd);
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    n_tests++;
    if (wc !== 1) begin n_fail++; $display("FAIL wr_we_cycles: got %0d expected 1", wc); end
    ram_op(1'b0, 1'b0, AW'(10'h005), 8'h00, lat, wc, rd);
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    n_tests++;
    if (rd !== 8'hA5) begin n_fail++; $display("FAIL rd_data: got %h expected a5", rd); end
    n_tests++;
    if (wc !== 0) begin n_fail++; $display("FAIL rd_we_cycles: got %0d expected 0", wc); end
    ram_op(1'b0, 1'b1, AW'(10'h006), 8'h77, lat, wc, rd);
    n_tests++;
    if (rdata0 !== 8'hA5) begin n_fail++; $display("FAIL rdata0_hold: got %h expected a5", rdata0); end
    n_tests++;
    if (rdata1 !== 8'h00) begin n_fail++; $display("FAIL rdata1_untouched: got %h expected 00", rdata1); end
  endtask

  task automatic test_tie;
    int lat, wc, t0, t1; logic [7:0] rd, r0, r1;
    ram_op(1'b0, 1'b1, AW'(10'h010), 8'h11, lat, wc, rd);
    ram_op(1'b1, 1'b1, AW'(10'h020), 8'h22, lat, wc, rd);
    ram_tie(t0, t1, r0, r1);
    n_tests++;
    if (t0 !== 3 || t1 !== 6) begin
      n_fail++; $display("FAIL tie1_order: got ack0@%0d ack1@%0d expected ack0@3 ack1@6", t0, t1);
    end
    n_tests++;
    if (r0 !== 8'h11 || r1 !== 8'h22) begin
      n_fail++; $display("FAIL tie1_data: got %h/%h expected 11/22", r0, r1);
    end
    // A lone requester-0 access moves the pointer so the next tie favours 1.
    ram_op(1'b0, 1'b0, AW'(10'h010), 8'h00, lat, wc, rd);
    ram_tie(t0, t1, r0, r1);
`ifdef ARB_MONITOR_PRIORITY_EN
    n_tests++;
    if (t0 !== 3 || t1 !== 6) begin
      n_fail++; $display("FAIL tie2_order: got ack0@%0d ack1@%0d expected ack0@3 ack1@6", t0, t1);
    end
`else
    n_tests++;
    if (t1 !== 3 || t0 !== 6) begin
      n_fail++; $display("FAIL tie2_order: got ack0@%0d ack1@%0d expected ack1@3 ack0@6", t0, t1);
    end
`endif
    n_tests++;
    if (r0 !== 8'h11 || r1 !== 8'h22) begin
      n_fail++; $display("FAIL tie2_data: got %h/%h expected 11/22", r0, r1);
    end
  endtask

  task automatic test_tx_contention;
    logic [7:0] sb [0:3];
    int ns = 0, na0 = 0, na1 = 0, ta0 = -1;
    for (int i = 0; i < 4; i++) sb[i] = 8'h00;
    @(posedge clk); #1;
    txreq0 = 1; txbyte0 = 8'h41; txreq1 = 1; txbyte1 = 8'h42;
    for (int n = 1; n <= 120; n++) begin
      @(posedge clk); #1;
      if (uart_transmit === 1'b1) begin
        if (ns < 4) sb[ns] = uart_tx_byte;
        ns++;
      end
      if (txack0 === 1'b1) begin na0++; if (ta0 < 0) ta0 = n; txreq0 = 0; end
      if (txack1 === 1'b1) begin na1++; txreq1 = 0; end
    end
    txreq0 = 0; txreq1 = 0;
    n_tests++;
    if (ns !== 2) begin n_fail++; $display("FAIL tx_strobes: got %0d expected 2", ns); end
    n_tests++;
    if (sb[0] !== 8'h41 || sb[1] !== 8'h42) begin
      n_fail++; $display("FAIL tx_bytes: got %h,%h expected 41,42", sb[0], sb[1]);
    end
    n_tests++;
    if (na0 !== 1 || na1 !== 1) begin
      n_fail++; $display("FAIL tx_acks: got %0d/%0d expected 1/1", na0, na1);
    end
    n_tests++;
    if (ta0 !== 2) begin n_fail++; $display("FAIL tx_latency: got %0d expected 2", ta0); end
    n_tests++;
    if (strobe_busy_err !== 1'b0) begin
      n_fail++; $display("FAIL tx_strobe_while_busy: got %b expected 0", strobe_busy_err);
    end
  endtask

  task automatic test_parallel;
    int la = -1, lt = -1, lat, wc, waited = 0; logic [7:0] tb, rd;
    tb = 8'h00;
    while (uart_is_transmitting && waited < 50) begin @(posedge clk); #1; waited++; end
    n_tests++;
    if (uart_is_transmitting !== 1'b0) begin
      n_fail++; $display("FAIL par_uart_idle: got busy %b expected 0", uart_is_transmitting);
    end
    @(posedge clk); #1;
    req1 = 1; we1 = 1; addr1 = AW'(10'h040); wdata1 = 8'h99;
    txreq1 = 1; txbyte1 = 8'h55;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ack1 === 1'b1 && la < 0) begin la = n; req1 = 0; end
      if (txack1 === 1'b1 && lt < 0) begin lt = n; tb = uart_tx_byte; txreq1 = 0; end
    end
    req1 = 0; txreq1 = 0;
    n_tests++;
    if (la !== 3 || lt !== 2) begin
      n_fail++; $display("FAIL par_latency: got ram %0d tx %0d expected ram 3 tx 2", la, lt);
    end
    n_tests++;
    if (tb !== 8'h55) begin n_fail++; $display("FAIL par_tx_byte: got %h expected 55", tb); end
    ram_op(1'b0, 1'b0, AW'(10'h040), 8'h00, lat, wc, rd);
    n_tests++;
    if (rd !== 8'h99) begin n_fail++; $display("FAIL par_write_data: got %h expected 99", rd); end
  endtask

  task automatic test_held;
    int a1 = -1, a2 = -1, nack = 0; logic prev = 0, dbl = 0;
    @(posedge clk); #1;
    req0 = 1; we0 = 0; addr0 = AW'(10'h005);
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (ack0 === 1'b1) begin
        nack++;
        if (prev) dbl = 1;
        if (a1 < 0) a1 = n;
        else if (a2 < 0) begin a2 = n; req0 = 0; end
      end
      prev = ack0;
    end
    req0 = 0;
    n_tests++;
    if (a1 !== 3 || a2 !== 7) begin
      n_fail++; $display("FAIL held_ack_times: got %0d,%0d expected 3,7", a1, a2);
    end
    n_tests++;
    if (nack !== 2 || dbl !== 1'b0) begin
      n_fail++; $display("FAIL held_ack_count: got %0d acks dbl=%b expected 2 dbl=0", nack, dbl);
    end
  endtask

  task automatic test_reset_mid;
    int lat, wc, nack = 0; logic [7:0] rd;
    ram_op(1'b0, 1'b1, AW'(10'h030), 8'h5A, lat, wc, rd);
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = AW'(10'h030); wdata0 = 8'hC3;
    @(posedge clk); #1;
    n_tests++;
    if (ram_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_access_we: got %b expected 1", ram_we); end
    #2 rst_n = 0;
    #1;
    n_tests++;
    if ({ack0, ack1, txack0, txack1, ram_we, uart_transmit} !== 6'b0) begin
      n_fail++; $display("FAIL rstmid_strobes: got %b expected 000000",
                         {ack0, ack1, txack0, txack1, ram_we, uart_transmit});
    end
    n_tests++;
    if ({rdata0, rdata1, ram_din, uart_tx_byte, ram_waddr, ram_raddr} !== '0) begin
      n_fail++; $display("FAIL rstmid_data: got %h %h %h %h %h %h expected all 0",
                         rdata0, rdata1, ram_din, uart_tx_byte, ram_waddr, ram_raddr);
    end
    req0 = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (ack0 === 1'b1) nack++;
    end
    rst_n = 1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (ack0 === 1'b1) nack++;
    end
    n_tests++;
    if (nack !== 0) begin n_fail++; $display("FAIL rstmid_no_ack: got %0d acks expected 0", nack); end
    ram_op(1'b0, 1'b0, AW'(10'h030), 8'h00, lat, wc, rd);
    n_tests++;
    if (rd !== 8'h5A) begin n_fail++; $display("FAIL rstmid_old_data: got %h expected 5a", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie();
    test_tx_contention();
    test_parallel();
    test_held();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
